// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan encoder.
// Holds the controller state type, the active-low segment code table
// (bit 6 = g .. bit 0 = a), the blank pattern and the special result codes.
// The blank pattern is only decoded when SEG7_ENC_BLANK_EN is defined
// (see seg7_pattern_lookup).
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StQualify,
    StHold,
    StWaitChange
  } seg7_state_e;

  localparam logic [6:0] SegCode0 = 7'b1000000;
  localparam logic [6:0] SegCode1 = 7'b1111001;
  localparam logic [6:0] SegCode2 = 7'b0100100;
  localparam logic [6:0] SegCode3 = 7'b0110000;
  localparam logic [6:0] SegCode4 = 7'b0011001;
  localparam logic [6:0] SegCode5 = 7'b0010010;
  localparam logic [6:0] SegCode6 = 7'b0000010;
  localparam logic [6:0] SegCode7 = 7'b1011000;
  localparam logic [6:0] SegCode8 = 7'b0000000;
  localparam logic [6:0] SegCode9 = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam logic [3:0] BcdBlank = 4'hF;
  localparam logic [3:0] BcdErr   = 4'hE;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational segment-pattern to digit decoder.
// Ports:
//   pattern - active-low 7-segment pattern (bit 6 = g .. bit 0 = a)
//   value   - decoded digit 0..9, BcdBlank for an all-off pattern when
//             SEG7_ENC_BLANK_EN is defined, BcdErr otherwise
//   err     - pattern is not in the code table
// Macro SEG7_ENC_BLANK_EN: decode the all-segments-off pattern as a blank.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    value = BcdErr;
    err   = 1'b1;
    case (pattern)
      SegCode0: begin value = 4'd0; err = 1'b0; end
      SegCode1: begin value = 4'd1; err = 1'b0; end
      SegCode2: begin value = 4'd2; err = 1'b0; end
      SegCode3: begin value = 4'd3; err = 1'b0; end
      SegCode4: begin value = 4'd4; err = 1'b0; end
      SegCode5: begin value = 4'd5; err = 1'b0; end
      SegCode6: begin value = 4'd6; err = 1'b0; end
      SegCode7: begin value = 4'd7; err = 1'b0; end
      SegCode8: begin value = 4'd8; err = 1'b0; end
      SegCode9: begin value = 4'd9; err = 1'b0; end
`ifdef SEG7_ENC_BLANK_EN
      SegBlank: begin value = BcdBlank; err = 1'b0; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_encoder.sv
// Recovers digit values from a multiplexed, active-low 7-segment display bus.
// A pattern/strobe pair must be seen unchanged for STABLE_CYCLES consecutive
// clocks before it is decoded and offered on a valid/ready handshake. After a
// transfer the same sample is ignored until the bus changes.
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-high reset
//   seg_in [6:0]         - active-low segment pattern, bit 6 = g .. bit 0 = a
//   dig_sel [N-1:0]      - one-hot digit strobe
//   out_valid/out_ready  - result handshake
//   out_bcd, out_digit   - decoded value and index of the active strobe
//   out_err              - qualified pattern not in the code table
//   overrun              - sticky: strobe moved while a result was held
// Macro SEG7_ENC_BLANK_EN: all-off pattern decodes as blank (4'hF, no error).
module seg7_scan_encoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 3,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_bcd,
  output logic [DigW-1:0]       out_digit,
  output logic                  out_err,
  output logic                  overrun
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  seg7_state_e           state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [6:0]            pat_q, pat_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  overrun_q, overrun_d;
  logic [3:0]            res_bcd_q, res_bcd_d;
  logic [DigW-1:0]       res_digit_q, res_digit_d;
  logic                  res_err_q, res_err_d;

  logic            sel_onehot;
  logic [DigW-1:0] sel_idx;
  logic            same;
  logic            start;
  logic            sampled;
  logic [3:0]      lk_value;
  logic            lk_err;

  // Decode the live sample; it is only captured on the cycle the result
  // qualifies, when seg_in equals the latched pattern anyway.
  seg7_pattern_lookup u_lookup (
    .pattern (seg_in),
    .value   (lk_value),
    .err     (lk_err)
  );

  always_comb begin
    sel_onehot = $onehot(dig_sel);
    same       = (seg_in == pat_q) && (dig_sel == sel_q);
    sel_idx    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) sel_idx = DigW'(i);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pat_q       <= '0;
      sel_q       <= '0;
      overrun_q   <= 1'b0;
      res_bcd_q   <= '0;
      res_digit_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pat_q       <= pat_d;
      sel_q       <= sel_d;
      overrun_q   <= overrun_d;
      res_bcd_q   <= res_bcd_d;
      res_digit_q <= res_digit_d;
      res_err_q   <= res_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pat_d       = pat_q;
    sel_d       = sel_q;
    overrun_d   = overrun_q;
    res_bcd_d   = res_bcd_q;
    res_digit_d = res_digit_q;
    res_err_d   = res_err_q;
    start       = 1'b0;
    sampled     = 1'b0;

    unique case (state_q)
      StIdle: begin
        start = sel_onehot;
      end
      StQualify: begin
        if (!sel_onehot) begin
          state_d = StIdle;
        end else if (same) begin
          count_d = (count_q >= StableCnt) ? StableCnt : count_q + 8'd1;
          sampled = 1'b1;
        end else begin
          start = 1'b1;
        end
      end
      StHold: begin
        // A transfer in the same cycle as a strobe move is not an overrun.
        if (out_ready) begin
          state_d = StWaitChange;
        end else if (dig_sel != sel_q) begin
          overrun_d = 1'b1;
        end
      end
      StWaitChange: begin
        if (!same) begin
          if (sel_onehot) start = 1'b1;
          else            state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      pat_d   = seg_in;
      sel_d   = dig_sel;
      count_d = 8'd1;
      state_d = StQualify;
      sampled = 1'b1;
    end

    if (sampled && (count_d >= StableCnt)) begin
      state_d     = StHold;
      res_bcd_d   = lk_value;
      res_err_d   = lk_err;
      res_digit_d = sel_idx;
    end
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == StHold);
    out_bcd   = res_bcd_q;
    out_digit = res_digit_q;
    out_err   = res_err_q;
    overrun   = overrun_q;
  end

endmodule

// File: doc/seg7_scan_encoder.md
SEG7_SCAN_ENCODER -- requirements
Module: seg7_scan_encoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, meaning the number of multiplexed digit strobes observed.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical samples needed to qualify a pattern (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port seg_in, input, 7 bits: active-low segment pattern, bit 6 = g through bit 0 = a.
REQ-006 SHALL have port dig_sel, input, NUM_DIGITS bits: one-hot digit strobe of the multiplexed display.
REQ-007 SHALL have port out_valid, output, 1 bit: a decoded result is presented.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port out_bcd, output, 4 bits: the recovered digit value.
REQ-010 SHALL have port out_digit, output, $clog2(NUM_DIGITS) bits (minimum 1): index of the strobe that was active.
REQ-011 SHALL have port out_err, output, 1 bit: the qualified pattern is not in the code table.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when a strobe change is lost while a result is held.

Function
REQ-013 SHALL use this code table (seg_in to out_bcd): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1011000=7, 0000000=8, 0010000=9.
REQ-014 SHALL treat a table miss as out_err=1 with out_bcd=4'hE.
REQ-015 SHALL implement the FSM states IDLE, QUALIFY, HOLD and WAIT_CHANGE.
REQ-016 IDLE: when dig_sel is exactly one-hot, SHALL latch seg_in and dig_sel, load count=1 and go to QUALIFY; zero-hot or multi-hot dig_sel SHALL keep the FSM in IDLE.
REQ-017 QUALIFY: when seg_in and dig_sel both equal the latched values, count SHALL increment; any mismatch SHALL relatch, load count=1 and stay in QUALIFY; a non-one-hot dig_sel SHALL return to IDLE.
REQ-018 QUALIFY: when count reaches STABLE_CYCLES, SHALL go to HOLD and assert out_valid on the next cycle (STABLE_CYCLES=1 gives valid 1 cycle after the first sample).
REQ-019 HOLD: out_valid, out_bcd, out_digit and out_err SHALL stay stable until out_valid and out_ready are both 1, then go to WAIT_CHANGE.
REQ-020 SHALL allow out_ready high before out_valid, and SHALL accept on the first cycle out_valid rises in that case.
REQ-021 HOLD: a dig_sel change away from the latched strobe SHALL set overrun and SHALL NOT alter the held result.
REQ-022 WAIT_CHANGE: SHALL stay in WAIT_CHANGE until seg_in or dig_sel differs from the latched values, then act as IDLE does on that cycle; the same sample SHALL never be reported twice.
REQ-023 A handshake and a strobe change in the same HOLD cycle SHALL complete the transfer and SHALL NOT set overrun.
REQ-024 The qualify counter SHALL saturate at STABLE_CYCLES and SHALL NOT wrap.

Reset
REQ-025 On rst SHALL go to IDLE and clear count, latched pattern and latched strobe.
REQ-026 On rst SHALL drive out_valid=0, out_bcd=0, out_digit=0, out_err=0 and overrun=0.
REQ-027 A reset asserted during HOLD SHALL drop the pending result with no handshake.
REQ-028 overrun SHALL clear only on rst.

Configuration
REQ-029 Macro SEG7_ENC_BLANK_EN defined: pattern 1111111 (all segments off) SHALL decode as out_bcd=4'hF with out_err=0.
REQ-030 Macro SEG7_ENC_BLANK_EN undefined: pattern 1111111 SHALL be a table miss per REQ-014.

Structure
REQ-031 The FSM state typedef, the ten code-table constants, the blank code 4'hF and the error code 4'hE SHALL live in the shared package seg7_pkg.
REQ-032 The combinational lookup SHALL be the sub-module seg7_pattern_lookup (7-bit pattern in; 4-bit value and err out).

Verification
REQ-033 dig_sel=001, seg_in=0100100 for 4 cycles, out_ready=1 -> out_valid on cycle 5, out_bcd=2, out_digit=0, out_err=0.
REQ-034 dig_sel=010, seg_in=1011000 for 3 cycles, then seg_in glitches for 1 cycle, then 4 more stable cycles -> exactly one result, out_bcd=7, out_digit=1.
REQ-035 out_ready=0 while dig_sel steps 001->010 during HOLD -> held result unchanged and overrun=1; out_ready=1 -> one transfer.
REQ-036 seg_in=1111111 held stable -> out_bcd=F, out_err=0 with SEG7_ENC_BLANK_EN defined; out_bcd=E, out_err=1 without it.
REQ-037 rst pulsed during HOLD -> out_valid=0 in the same cycle; no transfer follows until a new qualification.
REQ-038 dig_sel=011 for 10 cycles -> FSM stays in IDLE and out_valid stays 0.
